// File: rtl/sigmoid_backprop_pkg.sv
// Shared constants and FSM encoding for the sigmoid backward-pass block.
package sigmoid_backprop_pkg;

    localparam int BITS_DEF = 16;
    localparam int FRAC_DEF = BITS_DEF / 2;

    // 1.0 in the default fixed-point format
    localparam logic [BITS_DEF-1:0] ONE = BITS_DEF'(1 << FRAC_DEF);

    // Full-precision product width before the fractional shift
    localparam int PROD_W_DEF = 2 * BITS_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL1 = 2'd1,
        MUL2 = 2'd2,
        DONE = 2'd3
    } bp_state_t;

endpackage

// File: rtl/sigmoid_backprop_fxp_mul.sv
// Signed fixed-point multiply: full product, arithmetic shift by FRAC,
// then either wrap (truncate) or saturate to BITS. No rounding.
module fxp_mul #(
    parameter int BITS = 16,
    parameter int FRAC = BITS / 2,
    parameter bit SAT  = 1'b0
) (
    input  logic signed [BITS-1:0] a,
    input  logic signed [BITS-1:0] b,
    output logic signed [BITS-1:0] p
);

    logic signed [2*BITS-1:0] prod;

    assign prod = (2*BITS)'(a) * (2*BITS)'(b);

    generate
        if (SAT) begin : g_sat
            localparam logic signed [2*BITS-1:0] MAXV = {{(BITS+1){1'b0}}, {(BITS-1){1'b1}}};
            localparam logic signed [2*BITS-1:0] MINV = {{(BITS+1){1'b1}}, {(BITS-1){1'b0}}};
            logic signed [2*BITS-1:0] shd;
            assign shd = prod >>> FRAC;
            // clamp the shifted product into the representable range
            always_comb begin
                p = BITS'(shd);
                if (shd > MAXV)
                    p = BITS'(MAXV);
                else if (shd < MINV)
                    p = BITS'(MINV);
            end
        end else begin : g_wrap
            assign p = BITS'(prod >>> FRAC);
        end
    endgenerate

endmodule

// File: rtl/sigmoid_backprop.sv
// Sigmoid backward pass: grad = delta * z * (1 - z), one shared multiplier
// used over two cycles. Define SIGMOID_BP_SAT_EN to saturate intermediate
// results instead of wrapping.
module sigmoid_backprop
    import sigmoid_backprop_pkg::*;
#(
    parameter int BITS = BITS_DEF,
    parameter int FRAC = BITS / 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] z,
    input  logic [BITS-1:0] delta,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] grad,
    output logic            busy
);

`ifdef SIGMOID_BP_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic signed [BITS:0] ONE_X = (BITS+1)'(1) << FRAC;

    bp_state_t state, state_nx;

    logic signed [BITS-1:0] z_r, delta_r, t_r;
    logic signed [BITS:0]   omz_w;
    logic signed [BITS-1:0] omz;
    logic signed [BITS-1:0] mul_a, mul_b, mul_p;

    // 1 - z at one extra bit, then reduced like the multiplier output
    assign omz_w = ONE_X - (BITS+1)'(z_r);

`ifdef SIGMOID_BP_SAT_EN
    // clamp when the two top bits disagree (value outside BITS range)
    always_comb begin
        omz = BITS'(omz_w);
        if (omz_w[BITS] != omz_w[BITS-1])
            omz = omz_w[BITS] ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}};
    end
`else
    assign omz = BITS'(omz_w);
`endif

    // single multiplier: z*(1-z) in MUL1, delta*t in MUL2
    assign mul_a = (state == MUL2) ? delta_r : z_r;
    assign mul_b = (state == MUL2) ? t_r     : omz;

    fxp_mul #(.BITS(BITS), .FRAC(FRAC), .SAT(SAT_EN)) u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid)  state_nx = MUL1;
            MUL1:                state_nx = MUL2;
            MUL2:                state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default:             state_nx = IDLE;
        endcase
    end

    // operand capture, intermediate product, result and valid flag
    always_ff @(posedge clk) begin
        if (rst) begin
            z_r       <= '0;
            delta_r   <= '0;
            t_r       <= '0;
            grad      <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    z_r     <= z;
                    delta_r <= delta;
                end
                MUL1: t_r <= mul_p;
                MUL2: begin
                    grad      <= mul_p;
                    out_valid <= 1'b1;
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sigmoid_backprop.sv
// Self-checking bench for sigmoid_backprop: directed cases plus randomized
// transactions against an integer reference model.
module tb_sigmoid_backprop;

    localparam int BITS = 16;
    localparam int FRAC = 8;

`ifdef SIGMOID_BP_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] z;
    logic [BITS-1:0] delta;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] grad;
    logic            busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sigmoid_backprop #(.BITS(BITS), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z         (z),
        .delta     (delta),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grad      (grad),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // reduce an exact integer to 16 bits by wrap or clamp
    function automatic longint red(input longint v);
        logic signed [15:0] w;
        if (SAT) begin
            if (v > 32767)  return 32767;
            if (v < -32768) return -32768;
            return v;
        end
        w = v[15:0];
        return longint'(w);
    endfunction

    // grad = delta * z * (1 - z) in Q8.8 with floor division by 256
    function automatic logic [15:0] model(input logic [15:0] zz, input logic [15:0] dd);
        longint zi, di, omz, t, g;
        zi  = longint'($signed(zz));
        di  = longint'($signed(dd));
        omz = red(256 - zi);
        t   = red((zi * omz) >>> 8);
        g   = red((di * t) >>> 8);
        return g[15:0];
    endfunction

    // Present (zz,dd) in IDLE, check the pipeline timing and result, hold the
    // result for 'hold' cycles while offering (nz,nd), then release it.
    task automatic txn(input logic [15:0] zz, input logic [15:0] dd, input logic [15:0] exp,
                       input int hold, input logic [15:0] nz, input logic [15:0] nd,
                       input bit early_rdy);
        logic [15:0] held;
        int guard = 0;
        in_valid = 1'b1; z = zz; delta = dd;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = early_rdy;
        chk("busy_n1",     32'(busy),      32'd1);
        chk("in_ready_n1", 32'(in_ready),  32'd0);
        chk("ov_n1",       32'(out_valid), 32'd0);
        @(negedge clk);
        chk("ov_n2", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        @(negedge clk);
        chk("ov_n3",  32'(out_valid), 32'd1);
        chk("grad",   32'(grad),      32'(exp));
        held = grad;
        if (hold > 0) begin
            in_valid = 1'b1; z = nz; delta = nd;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_ov",       32'(out_valid), 32'd1);
            chk("hold_grad",     32'(grad),      32'(held));
            chk("hold_in_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("rel_ov",       32'(out_valid), 32'd0);
        chk("rel_in_ready", 32'(in_ready),  32'd1);
        chk("rel_busy",     32'(busy),      32'd0);
    endtask

    initial begin
        logic [15:0] zz, dd, nz, nd;
        int          hold;
        bit          have_next;

        rst = 1'b1; in_valid = 1'b0; z = '0; delta = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ov",       32'(out_valid), 32'd0);
        chk("rst_grad",     32'(grad),      32'd0);
        chk("rst_in_ready", 32'(in_ready),  32'd1);
        chk("rst_busy",     32'(busy),      32'd0);

        // directed values
        txn(16'h0080, 16'h0100, 16'h0040, 0, '0, '0, 1'b0);
        txn(16'h0000, 16'h7FFF, 16'h0000, 0, '0, '0, 1'b1);
        txn(16'h0100, 16'h7FFF, 16'h0000, 0, '0, '0, 1'b0);
        txn(16'h0080, 16'hFF00, 16'hFFC0, 0, '0, '0, 1'b0);
        txn(16'h7F00, 16'h0100, SAT ? 16'h8000 : 16'h7E00, 0, '0, '0, 1'b0);

        // backpressure: second input offered while held, accepted after release
        txn(16'h0040, 16'h0200, model(16'h0040, 16'h0200), 5, 16'h00C0, 16'hFE00, 1'b0);
        txn(16'h00C0, 16'hFE00, model(16'h00C0, 16'hFE00), 0, '0, '0, 1'b0);

        // reset while in MUL2 discards the result
        in_valid = 1'b1; z = 16'h0080; delta = 16'h0100;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_ov",       32'(out_valid), 32'd0);
        chk("mrst_grad",     32'(grad),      32'd0);
        chk("mrst_in_ready", 32'(in_ready),  32'd1);
        chk("mrst_busy",     32'(busy),      32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mrst_no_stale", 32'(out_valid), 32'd0);
        end

        // randomized transactions
        have_next = 1'b0; nz = '0; nd = '0;
        for (int k = 0; k < 40; k++) begin
            if (have_next) begin
                zz = nz; dd = nd;
            end else begin
                zz = 16'($signed($urandom_range(0, 384)) - 64);
                dd = 16'($urandom);
            end
            hold = $urandom_range(0, 3);
            nz   = 16'($signed($urandom_range(0, 384)) - 64);
            nd   = 16'($urandom);
            txn(zz, dd, model(zz, dd), hold, nz, nd, 1'($urandom));
            have_next = (hold > 0);
        end
        in_valid = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
